// File: rtl/fwd_scoreboard_pkg.sv
// fwd_scoreboard_pkg: shared widths, producer latency codes and slot record for the forwarding scoreboard.
package fwd_scoreboard_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_RIDX_W = 5;
  localparam int DEF_LAT_W = 2;
  localparam logic [DEF_LAT_W-1:0] LAT_ALU = 2'd0;
  localparam logic [DEF_LAT_W-1:0] LAT_LOAD = 2'd1;
  typedef struct packed {
    logic vld;
    logic [DEF_RIDX_W-1:0] rd;
    logic [DEF_LAT_W-1:0] cnt;
  } slot_t;
endpackage

// File: rtl/fwd_prio_sel.sv
// fwd_prio_sel: youngest-match priority selector for one source operand over the tracked slots.
module fwd_prio_sel
  import fwd_scoreboard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int RIDX_W = DEF_RIDX_W,
  parameter int LAT_W = DEF_LAT_W,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0]        vld,
  input  logic [DEPTH*RIDX_W-1:0] rd,
  input  logic [DEPTH*LAT_W-1:0]  cnt,
  input  logic [RIDX_W-1:0]       src,
  input  logic                    used,
  output logic                    hit,
  output logic                    ready,
  output logic [IDX_W-1:0]        idx
);
  // scan oldest to youngest so the youngest match is written last and wins
  always_comb begin
    hit = 1'b0;
    ready = 1'b0;
    idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (vld[k] && rd[k*RIDX_W +: RIDX_W] == src && used && src != '0) begin
        hit = 1'b1;
        ready = cnt[k*LAT_W +: LAT_W] == '0;
        idx = IDX_W'(k);
      end
    end
  end
endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: tracks in-flight register writers past EX, forwards ready results and requests stalls for pending ones.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int RIDX_W = DEF_RIDX_W,
  parameter int NUM_SRC = 2,
  parameter int DEPTH = 3,
  parameter int LAT_W = DEF_LAT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hold,
  input  logic                        ex_valid,
  input  logic                        ex_we,
  input  logic [RIDX_W-1:0]           ex_rd,
  input  logic [LAT_W-1:0]            ex_lat,
  input  logic [NUM_SRC*RIDX_W-1:0]   ex_src_idx,
  input  logic [NUM_SRC-1:0]          ex_src_used,
  input  logic [DEPTH*XLEN-1:0]       stage_data,
  output logic [NUM_SRC-1:0]          fwd_hit,
  output logic [NUM_SRC*XLEN-1:0]     fwd_data,
  output logic                        stall_req,
  output logic [$clog2(DEPTH+1)-1:0]  pending_cnt
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0] vld;
  logic [DEPTH*RIDX_W-1:0] rd;
  logic [DEPTH*LAT_W-1:0] cnt;
  logic [NUM_SRC-1:0] match, rdy;
  logic [IDX_W-1:0] idx [NUM_SRC];
  logic [LAT_W-1:0] lat_ins;
  logic ins;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_prio_sel #(.DEPTH(DEPTH), .RIDX_W(RIDX_W), .LAT_W(LAT_W), .IDX_W(IDX_W)) u_sel (
      .vld(vld),
      .rd(rd),
      .cnt(cnt),
      .src(ex_src_idx[i*RIDX_W +: RIDX_W]),
      .used(ex_src_used[i]),
      .hit(match[i]),
      .ready(rdy[i]),
      .idx(idx[i])
    );
  end
  always_comb begin
    fwd_hit = match & rdy;
    fwd_data = '0;
    for (int i = 0; i < NUM_SRC; i++)
      fwd_data[i*XLEN +: XLEN] = fwd_hit[i] ? stage_data[int'(idx[i])*XLEN +: XLEN] : '0;
    stall_req = ex_valid && |(match & ~rdy);
  end
  always_comb begin
    pending_cnt = '0;
    for (int k = 0; k < DEPTH; k++) pending_cnt = pending_cnt + CW'(vld[k]);
  end
  // a latency longer than the tracked window could never become ready in-slot
  assign lat_ins = (int'(ex_lat) >= DEPTH) ? LAT_W'(DEPTH - 1) : ex_lat;
  assign ins = ex_valid && ex_we && ex_rd != '0 && !stall_req;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      rd <= '0;
      cnt <= '0;
    end else if (!hold) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        vld[k] <= vld[k-1];
        rd[k*RIDX_W +: RIDX_W] <= rd[(k-1)*RIDX_W +: RIDX_W];
        cnt[k*LAT_W +: LAT_W] <= (cnt[(k-1)*LAT_W +: LAT_W] == '0) ? '0 : cnt[(k-1)*LAT_W +: LAT_W] - 1'b1;
      end
      vld[0] <= ins;
      rd[RIDX_W-1:0] <= ex_rd;
      cnt[LAT_W-1:0] <= lat_ins;
    end
  end
  lat_in_window: assert property (@(posedge clk) disable iff (rst)
    !(ex_valid && ex_we && !hold && int'(ex_lat) >= DEPTH))
    else $error("ex_lat %0d exceeds tracked depth, clamped", ex_lat);
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed plan scenarios plus randomized traffic checked against an age-based reference model.
module tb_fwd_scoreboard;
  localparam int XLEN = 32, RIDX_W = 5, NUM_SRC = 2, DEPTH = 3, LAT_W = 2;
  logic clk = 1'b0, rst = 1'b1, hold = 1'b0;
  logic ex_valid = 1'b0, ex_we = 1'b0;
  logic [RIDX_W-1:0] ex_rd = '0;
  logic [LAT_W-1:0] ex_lat = '0;
  logic [NUM_SRC*RIDX_W-1:0] ex_src_idx = '0;
  logic [NUM_SRC-1:0] ex_src_used = '0;
  logic [DEPTH*XLEN-1:0] stage_data = '0;
  logic [NUM_SRC-1:0] fwd_hit;
  logic [NUM_SRC*XLEN-1:0] fwd_data;
  logic stall_req;
  logic [1:0] pending_cnt;
  int n_cmp = 0, n_bad = 0;
  typedef struct {int rd; int lat; int age;} ent_t;
  ent_t q[$];
  bit exp_ins, exp_hold;

  fwd_scoreboard #(.XLEN(XLEN), .RIDX_W(RIDX_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .LAT_W(LAT_W)) dut (
    .clk(clk), .rst(rst), .hold(hold), .ex_valid(ex_valid), .ex_we(ex_we), .ex_rd(ex_rd),
    .ex_lat(ex_lat), .ex_src_idx(ex_src_idx), .ex_src_used(ex_src_used), .stage_data(stage_data),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .stall_req(stall_req), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input bit v, input bit we, input int rd, input int lat,
                        input int s0, input int s1, input bit [1:0] used, input bit h);
    ex_valid = v; ex_we = we; ex_rd = RIDX_W'(rd); ex_lat = LAT_W'(lat);
    ex_src_idx = {RIDX_W'(s1), RIDX_W'(s0)}; ex_src_used = used; hold = h;
  endtask

  task automatic set_sd(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    stage_data = {d2, d1, d0};
  endtask

  // an entry at age a has been in flight a advances; its result is ready once a >= lat
  task automatic cyc();
    logic [1:0] eh;
    logic [63:0] ed;
    bit st;
    #1;
    eh = '0; ed = '0; st = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      int s, b;
      s = int'(ex_src_idx[i*RIDX_W +: RIDX_W]);
      b = -1;
      foreach (q[j])
        if (ex_src_used[i] && s != 0 && q[j].rd == s && (b < 0 || q[j].age < q[b].age)) b = j;
      if (b >= 0) begin
        if (q[b].age >= q[b].lat) begin
          eh[i] = 1'b1;
          ed[i*32 +: 32] = stage_data[q[b].age*32 +: 32];
        end else st = 1'b1;
      end
    end
    st = st && ex_valid;
    chk("hit", fwd_hit, eh);
    chk("data", fwd_data, ed);
    chk("stall", stall_req, st);
    chk("pending", pending_cnt, q.size());
    exp_ins = ex_valid && ex_we && ex_rd != 0 && !st;
    exp_hold = hold;
    @(posedge clk);
    if (!exp_hold) begin
      foreach (q[j]) q[j].age++;
      while (q.size() > 0 && q[q.size()-1].age >= DEPTH) void'(q.pop_back());
      if (exp_ins) q.push_front('{int'(ex_rd), (int'(ex_lat) >= DEPTH) ? DEPTH - 1 : int'(ex_lat), 0});
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    #1;
    chk("rst_hit", fwd_hit, 0);
    chk("rst_data", fwd_data, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_pend", pending_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    // ALU chain
    set_in(1, 1, 5, 0, 0, 0, 2'b00, 0); cyc();
    set_in(1, 0, 0, 0, 5, 0, 2'b01, 0); set_sd(32'h1234, 0, 0);
    #1; chk("alu_hit", fwd_hit[0], 1); chk("alu_data", fwd_data[31:0], 32'h1234); chk("alu_stall", stall_req, 0);
    cyc();
    // load-use
    set_in(1, 1, 7, 1, 0, 0, 2'b00, 0); cyc();
    set_in(1, 1, 8, 0, 7, 0, 2'b01, 0); set_sd(0, 0, 0);
    #1; chk("lu_stall", stall_req, 1); cyc();
    set_sd(0, 32'hDEAD, 0);
    #1; chk("lu_hit", fwd_hit[0], 1); chk("lu_data", fwd_data[31:0], 32'hDEAD); chk("lu_stall2", stall_req, 0);
    cyc();
    // double write to x3
    set_in(1, 1, 3, 0, 0, 0, 2'b00, 0); cyc();
    cyc();
    set_in(1, 0, 0, 0, 3, 3, 2'b11, 0); set_sd(32'h22, 32'h11, 0);
    #1; chk("dw_hit", fwd_hit, 2'b11); chk("dw_data", fwd_data, {32'h22, 32'h22});
    cyc();
    // x0 and unused source
    set_in(0, 0, 0, 0, 0, 0, 2'b00, 0); repeat (3) cyc();
    set_in(1, 1, 0, 0, 0, 0, 2'b00, 0); cyc();
    set_in(1, 0, 0, 0, 0, 0, 2'b01, 0);
    #1; chk("x0_hit", fwd_hit, 0); chk("x0_stall", stall_req, 0); chk("x0_pend", pending_cnt, 0);
    cyc();
    // hold freezes a pending load
    set_in(1, 1, 9, 1, 0, 0, 2'b00, 0); cyc();
    set_in(1, 1, 4, 0, 9, 0, 2'b01, 1);
    for (int n = 0; n < 3; n++) begin
      #1; chk("hold_stall", stall_req, 1); chk("hold_pend", pending_cnt, 1); cyc();
    end
    set_in(1, 1, 4, 0, 9, 0, 2'b01, 0);
    #1; chk("hold_rel0", stall_req, 1); cyc();
    #1; chk("hold_rel1", stall_req, 0); chk("hold_rel1_hit", fwd_hit[0], 1); cyc();
    // async reset with three pending loads
    for (int r = 10; r < 13; r++) begin set_in(1, 1, r, 2, 0, 0, 2'b00, 0); cyc(); end
    set_in(1, 1, 13, 0, 12, 0, 2'b01, 0);
    #1; chk("ar_pre_stall", stall_req, 1); chk("ar_pre_pend", pending_cnt, 3);
    rst = 1'b1;
    #1; chk("ar_stall", stall_req, 0); chk("ar_pend", pending_cnt, 0); chk("ar_hit", fwd_hit, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    // randomized traffic over a small register range to provoke matches
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(0, 5) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 2),
             $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)), $urandom_range(0, 5) == 0);
      set_sd($urandom, $urandom, $urandom);
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the single-cycle forwarding logic.
- Tracks the register-writing instructions in flight beyond EX in a DEPTH-slot metadata shift register, with a per-slot latency countdown.
- For each of NUM_SRC EX source operands it selects the youngest matching producer. It forwards that producer's stage data when the result is ready, and raises a stall request when it is not (load-use and multi-cycle producers).
- Sits between the decode/EX pipeline registers and the EX operand muxes; the pipeline-stage result buses feed into it.

Parameters:
- XLEN, 32, datapath width
- RIDX_W, 5, register index width
- NUM_SRC, 2, source operands checked per EX instruction
- DEPTH, 3, tracked slots after EX (slot 0 = MEM, 1 = WB, 2 = post-WB)
- LAT_W, 2, width of the producer latency field

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- hold  in  1  global pipeline freeze (e.g. memory wait)
- ex_valid  in  1  EX holds a real instruction
- ex_we  in  1  EX instruction writes rd
- ex_rd  in  RIDX_W  EX destination
- ex_lat  in  LAT_W  cycles after entering slot 0 until result valid (ALU 0, load 1)
- ex_src_idx  in  NUM_SRC*RIDX_W  EX source indices, src i at [i*RIDX_W +: RIDX_W]
- ex_src_used  in  NUM_SRC  per-source read enable
- stage_data  in  DEPTH*XLEN  result value currently held in each slot's pipeline stage
- fwd_hit  out  NUM_SRC  per-source forward select
- fwd_data  out  NUM_SRC*XLEN  forwarded operand values
- stall_req  out  1  hold EX/earlier and inject a bubble
- pending_cnt  out  $clog2(DEPTH+1)  number of valid slots (debug/perf)

Behaviour:
- Slot state, registered:
  - vld
  - rd
  - cnt: remaining latency, LAT_W bits
- Reset (asynchronous, rst=1): all vld=0, rd=0, cnt=0. Consequently fwd_hit=0, fwd_data=0, stall_req=0, pending_cnt=0. Reset mid-operation discards every in-flight entry immediately.
- Outputs are combinational from slot state and inputs; zero added latency.
- Match for src i at slot k: vld[k] && rd[k]==src && ex_src_used[i] && src!=0. x0 never matches.
- Priority: the lowest k (youngest) wins. An older match behind a younger match to the same rd is ignored.
- Ready at slot k: cnt[k]==0.
- Winning slot ready: fwd_hit[i]=1, fwd_data[i]=stage_data[k].
- Winning slot not ready: fwd_hit[i]=0, fwd_data[i]=0, and the source contributes to stall_req.
- No match: fwd_hit[i]=0, fwd_data[i]=0; the operand comes from the register file. The register file bypasses same-cycle writes internally, so nothing older than slot DEPTH-1 needs forwarding.
- stall_req = OR over sources of "winning match not ready". It is asserted only when ex_valid=1.
- Update each clk edge, when hold=0:
  - slot k ← slot k-1 with cnt = sat0(cnt-1), for k=1..DEPTH-1.
  - slot 0 ← EX entry: vld = ex_valid && ex_we && ex_rd!=0 && !stall_req, rd=ex_rd, cnt=ex_lat. Otherwise slot 0 takes a bubble (vld=0).
  - The slot DEPTH-1 entry retires.
- hold=1: all slot state frozen, no counter decrement. hold dominates stall_req.
- ex_lat ≥ DEPTH: clamp to DEPTH-1 on insertion (simulation assertion flags it).
- Decrement saturates at 0, so a ready entry stays ready.
- pending_cnt = popcount(vld).

Decomposition:
- Shared package: XLEN, RIDX_W, LAT_W defaults; latency constants LAT_ALU=0, LAT_LOAD=1; slot struct typedef {vld, rd, cnt}.
- One natural sub-module, fwd_prio_sel: a per-source priority matcher over DEPTH slots returning hit/ready/index. Instantiate it NUM_SRC times via generate.

Test Plan:
- ALU chain: add x5 (lat 0) then consumer of x5 next cycle, stage_data[0]=0x1234 → fwd_hit[0]=1, fwd_data=0x1234, stall_req=0.
- Load-use: lw x7 (lat 1) followed by a consumer of x7 → cycle 1 stall_req=1 and slot 0 bubble inserted. Cycle 2: load in slot 1, cnt=0, stage_data[1]=0xDEAD → fwd_hit=1, data 0xDEAD, stall_req=0.
- Double write: x3 written at slot 1 (0x11) and slot 0 (0x22), both srcs = x3 → both fwd_hit=1, data 0x22.
- x0 and unused: producer rd=0 with src0=x0, and src1 matching but ex_src_used[1]=0 → fwd_hit=00, stall_req=0, pending_cnt=0.
- Hold: load in slot 0 with cnt=1, hold=1 for 3 cycles → slot state unchanged, stall_req stays 1 on a dependent consumer; releases one cycle after hold drops.
- Async reset mid-stall: assert rst between edges with 3 valid slots → pending_cnt=0, stall_req=0 immediately, without waiting for clk.
